// File: rtl/reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reset_sequencer_pkg
//  Purpose  : Shared encodings and helpers for the Propeller reset sequencer:
//             FSM state codes, reset-cause codes, counter sizing.
//  Revision : 1.0  initial release
// ============================================================================
package reset_sequencer_pkg;

    // FSM state encodings; 2'b11 is unused and recovers to RS_LOCK
    typedef enum logic [1:0] {
        RS_LOCK = 2'b00,
        RS_HOLD = 2'b01,
        RS_RUN  = 2'b10
    } seq_state_e;

    // Cause of the most recent reset
    typedef enum logic [1:0] {
        RC_POR    = 2'd0,
        RC_PLUG   = 2'd1,
        RC_BUTTON = 2'd2,
        RC_LOCK   = 2'd3
    } reset_cause_e;

    localparam logic [7:0] c_COUNT_MAX = 8'hFF;

    // Bits needed for a counter that runs 0 .. n-1 (at least one bit)
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Saturating increment for the 8-bit reset event counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == c_COUNT_MAX) ? v : 8'(v + 8'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_sync_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : reset_sequencer_sync_debounce
//  Purpose  : Multi-flop synchronizer for an asynchronous level, optionally
//             followed by a debouncer. CYCLES == 0 gives a plain synchronizer.
//             All flops reset to 0, so the output reads as asserted/unlocked
//             until the input has been seen high.
//  Revision : 1.0  initial release
// ============================================================================
module reset_sequencer_sync_debounce
    import reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CYCLES      = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic clean_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   w_sync;

    // Shift the asynchronous input through the synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end

    assign w_sync = sync_q[SYNC_STAGES-1];

    generate
        if (CYCLES == 0) begin : g_bypass
            assign clean_o = w_sync;
        end else begin : g_debounce
            localparam int              c_CNT_W = cnt_width(CYCLES);
            localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CYCLES - 1);

            logic [c_CNT_W-1:0] cnt_q, cnt_d;
            logic               clean_q, clean_d;

            // Count consecutive cycles where the synced level disagrees with the
            // accepted level; accept it on the CYCLES-th such cycle
            always_comb begin
                cnt_d   = '0;
                clean_d = clean_q;
                if (w_sync != clean_q) begin
                    if (cnt_q == c_CNT_LAST) clean_d = w_sync;
                    else                     cnt_d   = cnt_q + 1'b1;
                end
            end

            // Debounce state register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q   <= '0;
                    clean_q <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    clean_q <= clean_d;
                end
            end

            assign clean_o = clean_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : reset_sequencer
//  Purpose  : Merges Prop-plug reset, push-button and PLL lock into one clean,
//             registered active-low reset for the p1v core, with status
//             (state, last cause, saturating reset-event count).
//  Revision : 1.0  initial release
// ============================================================================
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 160000,
    parameter int HOLD_CYCLES     = 1600
) (
    input  logic       clock_160,
    input  logic       inp_resn,
    input  logic       pll_locked,
    input  logic       plug_resn,
    input  logic       pb_resn,
    output logic       ext_resn,
    output logic [1:0] seq_state,
    output logic [1:0] reset_cause,
    output logic [7:0] reset_count
);

    localparam int                  c_HOLD_W    = cnt_width(HOLD_CYCLES);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);

    logic w_lock_s;
    logic w_plug_s;
    logic w_pb_clean;
    logic w_req;

    seq_state_e          state_q, state_d;
    logic [c_HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    reset_cause_e        cause_q, cause_d;
    logic [7:0]          count_q, count_d;
    logic                ext_q, ext_d;

    reset_sequencer_sync_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .CYCLES      (0)
    ) u_sync_lock (
        .clk     (clock_160),
        .rst_n   (inp_resn),
        .async_i (pll_locked),
        .clean_o (w_lock_s)
    );

    reset_sequencer_sync_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .CYCLES      (0)
    ) u_sync_plug (
        .clk     (clock_160),
        .rst_n   (inp_resn),
        .async_i (plug_resn),
        .clean_o (w_plug_s)
    );

    reset_sequencer_sync_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .CYCLES      (DEBOUNCE_CYCLES)
    ) u_sync_pb (
        .clk     (clock_160),
        .rst_n   (inp_resn),
        .async_i (pb_resn),
        .clean_o (w_pb_clean)
    );

    assign w_req = !w_lock_s || !w_plug_s || !w_pb_clean;

    // Next-state, hold timer, cause/count bookkeeping; ext_resn follows next state
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        cause_d    = cause_q;
        count_d    = count_q;
        case (state_q)
            RS_LOCK: begin
                if (w_lock_s) state_d = RS_HOLD;
            end
            RS_HOLD: begin
                if (!w_lock_s) begin
                    state_d = RS_LOCK;
                end else if (w_req) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == c_HOLD_LAST) begin
                    state_d = RS_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RS_RUN: begin
                // Lock loss outranks plug, plug outranks button
                if (!w_lock_s) begin
                    state_d = RS_LOCK;
                    cause_d = RC_LOCK;
                    count_d = sat_inc8(count_q);
                end else if (w_req) begin
                    state_d = RS_HOLD;
                    cause_d = w_plug_s ? RC_BUTTON : RC_PLUG;
                    count_d = sat_inc8(count_q);
                end
            end
            default: state_d = RS_LOCK;
        endcase
        ext_d = (state_d == RS_RUN);
    end

    // Sequencer registers
    always_ff @(posedge clock_160 or negedge inp_resn) begin
        if (!inp_resn) begin
            state_q    <= RS_LOCK;
            hold_cnt_q <= '0;
            cause_q    <= RC_POR;
            count_q    <= '0;
            ext_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            cause_q    <= cause_d;
            count_q    <= count_d;
            ext_q      <= ext_d;
        end
    end

    assign ext_resn    = ext_q;
    assign seq_state   = state_q;
    assign reset_cause = cause_q;
    assign reset_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reset_sequencer
//  Purpose  : Directed self-checking bench for reset_sequencer
//             (SYNC_STAGES=2, DEBOUNCE_CYCLES=8, HOLD_CYCLES=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_reset_sequencer;
    import reset_sequencer_pkg::*;

    localparam int c_SYNC = 2;
    localparam int c_DEB  = 8;
    localparam int c_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       plug_resn;
    logic       pb_resn;
    logic       ext_resn;
    logic [1:0] seq_state;
    logic [1:0] reset_cause;
    logic [7:0] reset_count;

    int n_checks = 0;
    int n_pass   = 0;

    reset_sequencer #(
        .SYNC_STAGES     (c_SYNC),
        .DEBOUNCE_CYCLES (c_DEB),
        .HOLD_CYCLES     (c_HOLD)
    ) dut (
        .clock_160   (clk),
        .inp_resn    (rst_n),
        .pll_locked  (pll_locked),
        .plug_resn   (plug_resn),
        .pb_resn     (pb_resn),
        .ext_resn    (ext_resn),
        .seq_state   (seq_state),
        .reset_cause (reset_cause),
        .reset_count (reset_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle plug pulse; returns 1 edge after the falling drive
    task automatic plug_pulse();
        plug_resn = 1'b0;
        step(1);
        plug_resn = 1'b1;
    endtask

    initial begin
        bit bounce_ok;

        // ---------------- 1. power-on ----------------
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        plug_resn  = 1'b1;
        pb_resn    = 1'b1;
        step(3);
        check("rst_ext",   32'(ext_resn),    32'd0);
        check("rst_state", 32'(seq_state),   32'(RS_LOCK));
        check("rst_cause", 32'(reset_cause), 32'(RC_POR));
        check("rst_count", 32'(reset_count), 32'd0);

        rst_n = 1'b1;
        step(c_SYNC);
        check("por_lock_state", 32'(seq_state), 32'(RS_LOCK));
        step(1);
        check("por_hold_state", 32'(seq_state), 32'(RS_HOLD));
        // The debounced button resets to "pressed", so the hold window only
        // starts once it has been seen released: SYNC + DEB, then HOLD edges.
        step(c_SYNC + c_DEB + c_HOLD - 1 - (c_SYNC + 1));
        check("por_ext_low",  32'(ext_resn), 32'd0);
        step(1);
        check("por_ext_high", 32'(ext_resn),    32'd1);
        check("por_run",      32'(seq_state),   32'(RS_RUN));
        check("por_cause",    32'(reset_cause), 32'(RC_POR));
        check("por_count",    32'(reset_count), 32'd0);

        // ---------------- 2. single-cycle plug pulse ----------------
        plug_pulse();
        step(1);
        check("plug_ext_still_high", 32'(ext_resn), 32'd1);
        step(1);
        check("plug_ext_low", 32'(ext_resn),  32'd0);
        check("plug_hold",    32'(seq_state), 32'(RS_HOLD));
        step(c_HOLD - 1);
        check("plug_hold_end_low", 32'(ext_resn), 32'd0);
        step(1);
        check("plug_ext_high", 32'(ext_resn),    32'd1);
        check("plug_cause",    32'(reset_cause), 32'(RC_PLUG));
        check("plug_count",    32'(reset_count), 32'd1);

        // ---------------- 3. button bounce then stable press ----------------
        bounce_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            pb_resn = (((i / 3) % 2) == 0) ? 1'b0 : 1'b1;
            step(1);
            if (ext_resn !== 1'b1) bounce_ok = 1'b0;
        end
        check("bounce_no_reset", 32'(bounce_ok), 32'd1);
        pb_resn = 1'b0;
        step(c_SYNC + c_DEB);
        check("pb_before_accept", 32'(ext_resn), 32'd1);
        pb_resn = 1'b1;
        step(1);
        check("pb_ext_low", 32'(ext_resn),    32'd0);
        check("pb_hold",    32'(seq_state),   32'(RS_HOLD));
        check("pb_cause",   32'(reset_cause), 32'(RC_BUTTON));
        check("pb_count",   32'(reset_count), 32'd2);
        for (int k = 0; k < 100 && ext_resn !== 1'b1; k++) step(1);
        check("pb_back_to_run", 32'(ext_resn), 32'd1);

        // ---------------- 4. PLL lock lost for 4 cycles ----------------
        pll_locked = 1'b0;
        step(3);
        check("lock_state", 32'(seq_state),   32'(RS_LOCK));
        check("lock_ext",   32'(ext_resn),    32'd0);
        check("lock_cause", 32'(reset_cause), 32'(RC_LOCK));
        check("lock_count", 32'(reset_count), 32'd3);
        step(1);
        pll_locked = 1'b1;
        step(3);
        check("lock_relock_hold", 32'(seq_state), 32'(RS_HOLD));
        step(c_HOLD - 1);
        check("lock_hold_end_low", 32'(ext_resn), 32'd0);
        step(1);
        check("lock_run", 32'(ext_resn), 32'd1);

        // ---------------- 5. re-request during HOLD ----------------
        plug_pulse();
        step(2);
        check("rehold_enter", 32'(seq_state), 32'(RS_HOLD));
        step(5);
        plug_resn = 1'b0;
        step(4);
        plug_resn = 1'b1;
        step(7);
        check("rehold_old_deadline", 32'(ext_resn), 32'd0);
        // Request clears SYNC edges after the release; HOLD edges from there
        step(c_SYNC + c_HOLD - 1 - 7);
        check("rehold_new_deadline_low", 32'(ext_resn), 32'd0);
        step(1);
        check("rehold_ext_high", 32'(ext_resn),    32'd1);
        check("rehold_count",    32'(reset_count), 32'd4);

        // ---------------- 6. counter saturation, async reset ----------------
        for (int p = 1; p <= 300; p++) begin
            plug_pulse();
            step(c_SYNC + c_HOLD);
            if (p == 250) check("count_254", 32'(reset_count), 32'd254);
            if (p == 251) check("count_255", 32'(reset_count), 32'd255);
        end
        check("count_saturated", 32'(reset_count), 32'd255);
        check("sat_run",         32'(seq_state),   32'(RS_RUN));

        plug_pulse();
        step(10);
        check("mid_hold", 32'(seq_state), 32'(RS_HOLD));
        rst_n = 1'b0;
        #1;
        check("async_ext",   32'(ext_resn),    32'd0);
        check("async_state", 32'(seq_state),   32'(RS_LOCK));
        check("async_cause", 32'(reset_cause), 32'(RC_POR));
        check("async_count", 32'(reset_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
